// File: rtl/lsu_pkg.sv
// Shared definitions for the sized load/store unit.
//   - size encodings for byte / half / word / doubleword accesses
//   - FSM state encoding (also exported on the debug port)
//   - lane_bits(): log2 of the number of byte lanes in a data word
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Number of address bits that select a byte lane inside one memory word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   size       : access size (SZ_B..SZ_D)
//   sign_ext   : loads only, 1 = sign-extend the extracted field
//   off        : byte offset of the access inside the memory word
//   wdata      : right-aligned store data
//   rdata_word : raw memory read word
//   lane_wdata : store data replicated across every lane group
//   lane_bmask : byte enables for the selected lanes
//   load_data  : extracted and extended load result
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = lane_bits(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_word,
  output logic [DATA_W-1:0] lane_wdata,
  output logic [NB-1:0]     lane_bmask,
  output logic [DATA_W-1:0] load_data
);

  int                nbytes;
  int                msb;
  logic [NB-1:0]     base_mask;
  logic [DATA_W-1:0] field;

  always_comb begin
    lane_wdata = '0;
    load_data  = '0;
    base_mask  = '0;
    // Clamp so a size wider than the data word degrades to a full-word access.
    nbytes = 1 << size;
    if (nbytes > NB) nbytes = NB;
    msb = 8 * nbytes - 1;

    for (int i = 0; i < NB; i++) begin
      base_mask[i]         = (i < nbytes);
      lane_wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
    lane_bmask = base_mask << off;

    field = rdata_word >> {off, 3'b000};
    // Bits above the field's MSB are filled with its sign bit or zero; a
    // full-width access has no bits above the MSB and passes through.
    for (int i = 0; i < DATA_W; i++) begin
      load_data[i] = (i <= msb) ? field[i] : (sign_ext & field[msb]);
    end
  end

endmodule

// File: rtl/lsu_sized.sv
// Sized load/store unit between the ALU address and the data memory.
//   clock, reset (async, active-low)
//   start/we/size/sign_ext/addr/wdata : access request, sampled in IDLE
//   busy/done/fault/rdata             : datapath status and load result
//   mem_*                             : memory request/ack port
//   state_dbg                         : current FSM state
//
// Memory handshake: mem_req rises with mem_we/mem_addr/mem_wdata/mem_bmask
// valid and holds them stable until the first cycle mem_ack is high; that
// cycle completes the transfer (mem_rdata valid with it on loads). An ack
// while mem_req is low is ignored. If no ack arrives within TIMEOUT request
// cycles the request is withdrawn and the access completes with fault.
module lsu_sized
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MEM_AW  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_bmask,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output lsu_state_e          state_dbg
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = lane_bits(DATA_W);
  localparam int HI_LSB = MEM_AW + OFF_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             req_we;
  logic             req_sign;
  logic [1:0]       req_size;
  logic [OFF_W-1:0] req_off;

  logic [OFF_W-1:0]  off_in;
  logic [OFF_W-1:0]  size_mask;
  logic              misaligned;
  logic              out_of_range;
  logic [1:0]        al_size;
  logic              al_sign;
  logic [OFF_W-1:0]  al_off;
  logic [DATA_W-1:0] lane_wdata;
  logic [NB-1:0]     lane_bmask;
  logic [DATA_W-1:0] load_data;

  assign off_in       = addr[OFF_W-1:0];
  assign size_mask    = OFF_W'((1 << size) - 1);
  assign misaligned   = |(off_in & size_mask);
  assign out_of_range = |addr[ADDR_W-1:HI_LSB];

  // One aligner serves both directions: in IDLE it steers the incoming store,
  // during REQ it extracts the load using the registered request fields.
  assign al_size = (state == IDLE) ? size     : req_size;
  assign al_sign = (state == IDLE) ? sign_ext : req_sign;
  assign al_off  = (state == IDLE) ? off_in   : req_off;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size       (al_size),
    .sign_ext   (al_sign),
    .off        (al_off),
    .wdata      (wdata),
    .rdata_word (mem_rdata),
    .lane_wdata (lane_wdata),
    .lane_bmask (lane_bmask),
    .load_data  (load_data)
  );

  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bmask <= '0;
      req_we    <= 1'b0;
      req_sign  <= 1'b0;
      req_size  <= SZ_B;
      req_off   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          fault <= 1'b0;
          if (start) begin
            if (misaligned || out_of_range) begin
              // Bad address never reaches memory.
              state <= RESP;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= REQ;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= addr[HI_LSB-1:OFF_W];
              mem_wdata <= lane_wdata;
              mem_bmask <= we ? lane_bmask : '1;
              req_we    <= we;
              req_sign  <= sign_ext;
              req_size  <= size;
              req_off   <= off_in;
              cnt       <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= RESP;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
            if (!req_we) rdata <= load_data;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= RESP;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sized.sv
// Directed bench for lsu_sized: a driver issues accesses and pushes the
// expected memory request, response and completion cycle into queues; a
// monitor pops and compares whenever the DUT raises mem_req or done.
module tb_lsu_sized;
  import lsu_pkg::*;

  localparam int DW   = 64;
  localparam int RSPW = DW + 1;          // {fault, rdata}
  localparam int MQW  = 1 + 8 + 8 + DW;  // {we, mem_addr, bmask, lane data}

  logic          clock;
  logic          reset;
  logic          start;
  logic          we;
  logic [1:0]    size;
  logic          sign_ext;
  logic [63:0]   addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          fault;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_bmask;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  lsu_state_e    state_dbg;

  lsu_sized #(.DATA_W(64), .ADDR_W(64), .MEM_AW(8), .TIMEOUT(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bmask (mem_bmask),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [RSPW-1:0] exp_q[$];
  logic [MQW-1:0]  mreq_q[$];
  int              lat_q[$];
  int              checks = 0;
  int              errors = 0;
  logic            busy_seen = 1'b0;

  // memory responder controls
  int          ack_delay = 0;
  logic [63:0] mem_word  = '0;
  logic        late_ack  = 1'b0;
  int          wait_cnt  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        late_ack  = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      prev_req = 1'b0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (mem_req && !prev_req) begin
        if (mreq_q.size() == 0) begin
          check("unexpected_mem_req", 128'(mem_addr), 128'hFFFF);
        end else begin
          logic [MQW-1:0] e;
          logic [63:0]    lanes;
          e = mreq_q.pop_front();
          for (int i = 0; i < 8; i++) lanes[8*i +: 8] = {8{e[DW+i]}};
          check("mem_req_fields",
                128'({mem_we, mem_addr, mem_bmask, (e[MQW-1] ? (mem_wdata & lanes) : 64'h0)}),
                128'(e));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 128'({fault, rdata}), 128'h1_0000_0000_0000_0000_0000);
        end else begin
          logic [RSPW-1:0] r;
          int              l;
          r = exp_q.pop_front();
          l = lat_q.pop_front();
          check("resp_fault_rdata", 128'({fault, rdata}), 128'(r));
          check("done_cycle", 128'(cyc), 128'(l));
          check("idle_at_done", 128'({busy, mem_req}), 128'(2'b00));
        end
      end
      prev_req = mem_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic i_we, input logic [1:0] i_size, input logic i_sx,
                       input logic [63:0] i_addr, input logic [63:0] i_wdata,
                       input int i_delay, input logic [63:0] i_mword,
                       input logic e_resp, input logic e_fault, input logic [63:0] e_rdata,
                       input int e_lat, input logic e_mreq, input logic [7:0] e_maddr,
                       input logic [7:0] e_mask, input logic [63:0] e_mwdata);
    @(posedge clock);
    #1;
    ack_delay = i_delay;
    mem_word  = i_mword;
    if (e_mreq) mreq_q.push_back({i_we, e_maddr, e_mask, e_mwdata});
    if (e_resp) begin
      exp_q.push_back({e_fault, e_rdata});
      lat_q.push_back(cyc + e_lat);
    end
    we       = i_we;
    size     = i_size;
    sign_ext = i_sx;
    addr     = i_addr;
    wdata    = i_wdata;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // A start that must be ignored (DUT busy or in RESP).
  task automatic poke_start();
    @(posedge clock);
    #1;
    we    = 1'b0;
    size  = SZ_D;
    addr  = 64'h10;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      lat_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] R1 = 64'hFFFF_FFFF_FFFF_FF80;
  localparam logic [63:0] R2 = 64'hFFFF_FFFF_8000_0001;
  localparam logic [63:0] R3 = 64'h0000_0000_0000_F00D;
  localparam logic [63:0] R4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] R6 = 64'h0000_0000_DEAD_BEEF;

  initial begin
    reset = 1'b0; start = 1'b0; we = 1'b0; size = SZ_B; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs",
          128'({busy, done, fault, mem_req, mem_we, mem_addr, mem_bmask}), 128'(0));
    check("reset_data", 128'({rdata, mem_wdata}), 128'(0));
    check("reset_state", 128'(state_dbg), 128'(IDLE));
    @(negedge clock);
    reset = 1'b1;

    // 1: signed byte load, lane 5, ack in first REQ cycle; start in RESP ignored
    issue(1'b0, SZ_B, 1'b1, 64'h0D, '0, 0, 64'h0000_8000_0000_0000,
          1'b1, 1'b0, R1, 2, 1'b1, 8'd1, 8'hFF, 64'h0);
    poke_start();
    wait_done();
    // 2: store half at 0x12
    issue(1'b1, SZ_H, 1'b0, 64'h12, 64'hBEEF, 0, '0,
          1'b1, 1'b0, R1, 2, 1'b1, 8'd2, 8'h0C, 64'h0000_0000_BEEF_0000);
    wait_done();
    // store byte into top lane, one wait cycle
    issue(1'b1, SZ_B, 1'b0, 64'h07, 64'hA5, 1, '0,
          1'b1, 1'b0, R1, 3, 1'b1, 8'd0, 8'h80, 64'hA500_0000_0000_0000);
    wait_done();
    // 3: misaligned word load
    busy_seen = 1'b0;
    issue(1'b0, SZ_W, 1'b0, 64'h06, '0, 0, '0,
          1'b1, 1'b1, R1, 1, 1'b0, 8'd0, 8'h00, 64'h0);
    wait_done();
    check("misaligned_no_busy", 128'(busy_seen), 128'(0));
    // 4: out-of-range dword load
    busy_seen = 1'b0;
    issue(1'b0, SZ_D, 1'b0, 64'h800, '0, 0, '0,
          1'b1, 1'b1, R1, 1, 1'b0, 8'd0, 8'h00, 64'h0);
    wait_done();
    check("oor_no_busy", 128'(busy_seen), 128'(0));
    // signed word, zero-extended half, dword pass-through
    issue(1'b0, SZ_W, 1'b1, 64'h04, '0, 0, 64'h8000_0001_0000_0000,
          1'b1, 1'b0, R2, 2, 1'b1, 8'd0, 8'hFF, 64'h0);
    wait_done();
    issue(1'b0, SZ_H, 1'b0, 64'h06, '0, 2, 64'hF00D_0000_0000_0000,
          1'b1, 1'b0, R3, 4, 1'b1, 8'd0, 8'hFF, 64'h0);
    wait_done();
    issue(1'b0, SZ_D, 1'b1, 64'h18, '0, 0, R4,
          1'b1, 1'b0, R4, 2, 1'b1, 8'd3, 8'hFF, 64'h0);
    wait_done();
    // 5: ack withheld -> 15 request cycles then fault; start while busy ignored
    issue(1'b0, SZ_D, 1'b0, 64'h08, '0, 1000, 64'h1111_1111_1111_1111,
          1'b1, 1'b1, R4, 16, 1'b1, 8'd1, 8'hFF, 64'h0);
    poke_start();
    wait_done();
    late_ack = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("late_ack_rdata_held", 128'(rdata), 128'(R4));
    check("late_ack_idle", 128'({busy, mem_req, state_dbg}), 128'({2'b00, IDLE}));
    // 6: reset on the third REQ cycle
    issue(1'b0, SZ_W, 1'b0, 64'h24, '0, 1000, '0,
          1'b0, 1'b0, '0, 0, 1'b1, 8'd4, 8'hFF, 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_req_busy", 128'({mem_req, busy}), 128'(2'b00));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_reset_rdata", 128'(rdata), 128'(0));
    issue(1'b0, SZ_W, 1'b0, 64'h24, '0, 3, 64'hDEAD_BEEF_1234_5678,
          1'b1, 1'b0, R6, 5, 1'b1, 8'd4, 8'hFF, 64'h0);
    wait_done();

    repeat (3) @(posedge clock);
    check("mreq_queue_drained", 128'(mreq_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_sized.md
Name: lsu_sized

Overview:
- Parametrised load/store unit between the datapath's ALU address output and the data memory.
- It replaces the fixed 64-bit, single-cycle memory access with four access sizes: byte, half, word and doubleword.
- It adds sign/zero extension, byte-lane write masks, a variable-latency req/ack memory handshake with timeout, and fault detection for misaligned or out-of-range addresses.
- The datapath stalls (PC hold) while busy is high.

Parameters:
- DATA_W, 64, datapath/memory word width; must be a power of two, at least 16.
- ADDR_W, 64, byte-address width from the ALU.
- MEM_AW, 8, memory word-address width; depth is 2^MEM_AW words.
- TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack before a fault is raised.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: reset is asynchronous and active-low.
- start, in, 1: one-cycle request to begin an access; sampled only in IDLE.
- we, in, 1: 1 = store, 0 = load.
- size, in, 2: 00 byte, 01 half, 10 word, 11 doubleword.
- sign_ext, in, 1: loads only; 1 = sign-extend, 0 = zero-extend.
- addr, in, ADDR_W: byte address.
- wdata, in, DATA_W: store data, right-aligned.
- busy, out, 1: high from the cycle after start until done.
- done, out, 1: one-cycle completion pulse.
- fault, out, 1: valid with done; 1 = misaligned, out of range, or timeout.
- rdata, out, DATA_W: extended load result; held until the next load's done.
- mem_req, out, 1: memory request, held until ack.
- mem_we, out, 1: memory write enable, qualified by mem_req.
- mem_addr, out, MEM_AW: memory word address.
- mem_wdata, out, DATA_W: lane-positioned store data.
- mem_bmask, out, DATA_W/8: byte-lane enables; all ones on loads.
- mem_ack, in, 1: memory completion; for loads, mem_rdata is valid in the same cycle.
- mem_rdata, in, DATA_W: memory read word.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - busy, done, fault, mem_req, mem_we = 0.
  - rdata, mem_addr, mem_wdata, mem_bmask, timeout counter = 0.
- Lane offset and word address:
  - off = addr[log2(DATA_W/8)-1:0].
  - mem_addr = addr[MEM_AW+log2(DATA_W/8)-1 : log2(DATA_W/8)].
- Misalignment checks:
  - half: off[0] != 0.
  - word: off[1:0] != 0.
  - dword: off != 0.
  - byte: never misaligned.
- Out of range: any addr bit above the mem_addr field is nonzero.
- State IDLE:
  - start=1 with a bad address: go to RESP with fault latched; no mem_req is issued.
  - start=1 with a good address: register all request fields, go to REQ.
  - start=0: stay in IDLE.
- State REQ:
  - mem_req=1 and busy=1.
  - mem_ack=1: capture the result and go to RESP. The earliest ack is the first REQ cycle.
  - No ack: increment the counter. When the counter reaches TIMEOUT with no ack, go to RESP with fault=1 and drop mem_req.
- State RESP:
  - done=1, busy=0, then return to IDLE.
  - A start in RESP is ignored.
- Latency: start at cycle N with ack at the first REQ cycle gives done at N+2. Each wait cycle adds 1. A bad address gives done at N+1.
- A start while busy is ignored; there is no queueing.
- Store lanes:
  - mem_wdata = wdata[8*2^size-1:0] replicated across the word; only the selected lanes are meaningful.
  - mem_bmask = (2^(2^size)-1) << off.
- Load extraction:
  - field = mem_rdata >> (8*off), truncated to 8*2^size bits.
  - Extended per sign_ext; doubleword is passed through unchanged.
- rdata is unchanged on stores, faults and timeouts.
- An ack arriving while in IDLE or RESP (for example a late ack after a timeout) is ignored.
- Reset asserted mid-REQ: mem_req drops immediately (asynchronously); no done is generated.
- Memory contract: mem_addr, mem_we, mem_wdata and mem_bmask stay stable while mem_req=1.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - state encodings IDLE, REQ, RESP;
  - the function log2 of DATA_W/8.
- Natural sub-module lsu_lane_align: combinational lane shift, mask generation and extension. The parent holds the FSM and registers.

Test Plan:
1. Load byte, signed: addr=0x0D, sign_ext=1, mem_ack in the first REQ cycle, mem_rdata=0x0000_8000_0000_0000 → mem_addr=1, mem_bmask=0xFF; done at start+2; rdata=0xFFFF_FFFF_FFFF_FF80 (byte lane 5 = 0x80); fault=0.
2. Store half at addr=0x12, wdata=0xBEEF → mem_addr=2, mem_bmask=0x0C, mem_wdata lanes 3:2 = 0xBEEF, mem_we=1; rdata unchanged.
3. Misaligned word load at addr=0x06 → no mem_req; done and fault at start+1; busy never set.
4. Load dword at addr=0x800 (out of range for MEM_AW=8) → fault at start+1; no mem_req.
5. Ack withheld: mem_req held for 15 cycles, then done and fault with mem_req=0. A late ack one cycle later is ignored; rdata unchanged.
6. Reset pulled low on the 3rd REQ cycle → mem_req and busy are 0 immediately; no done. After release, start with a word load at addr=0x24 and ack after 3 wait cycles → done at start+5; zero-extended rdata correct.
